// File: rtl/mem_access_unit.sv
// mem_access_unit: data-memory access sequencer for the multi-cycle core.
// Takes one load/store request per instruction, checks size/alignment, runs a single
// outstanding req/ack bus transfer and returns the aligned, extended load result.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   start, is_load, funct3,
//   addr, wdata                      request from the control FSM (sampled in IDLE)
//   busy, done, err                  status; done is a one-cycle pulse, err valid with done
//   mem_rdata                        extended load result, updated only on a successful load
//   bus_req, bus_we, bus_addr,
//   bus_wstrb, bus_wdata             data-bus request side, held stable until bus_ack
//   bus_ack, bus_rdata               data-bus response side
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        is_load,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] mem_rdata,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_CHECK, S_REQ, S_DONE} state_t;

   state_t             state_q;
   logic               is_load_q;
   logic [2:0]         funct3_q;
   logic [31:0]        addr_q;
   logic [31:0]        wdata_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               busy_q, done_q, err_q, bus_req_q, bus_we_q;
   logic [31:0]        mem_rdata_q, bus_addr_q, bus_wdata_q;
   logic [3:0]         bus_wstrb_q;

   logic [1:0]         off_c;
   logic               legal_c;
   logic               timeout_c;
   logic [3:0]         strb_c;
   logic [31:0]        wdata_rep_c;
   logic [7:0]         byte_c;
   logic [15:0]        half_c;
   logic [31:0]        ext_c;

   // Legality, lane strobes, store replication and load extraction from captured request
   always_comb begin
      off_c       = addr_q[1:0];
      legal_c     = 1'b0;
      strb_c      = 4'b1111;
      wdata_rep_c = wdata_q;
      byte_c      = bus_rdata[{off_c, 3'b000} +: 8];
      half_c      = bus_rdata[{off_c[1], 4'b0000} +: 16];
      ext_c       = bus_rdata;

      case (funct3_q)
         3'b000:  legal_c = 1'b1;
         3'b001:  legal_c = ~addr_q[0];
         3'b010:  legal_c = (addr_q[1:0] == 2'b00);
         3'b100:  legal_c = is_load_q;
         3'b101:  legal_c = is_load_q & ~addr_q[0];
         default: legal_c = 1'b0;
      endcase

      case (funct3_q[1:0])
         2'b00: begin
            strb_c      = 4'b0001 << off_c;
            wdata_rep_c = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            strb_c      = 4'b0011 << off_c;
            wdata_rep_c = {2{wdata_q[15:0]}};
         end
         default: begin
            strb_c      = 4'b1111;
            wdata_rep_c = wdata_q;
         end
      endcase

      case (funct3_q)
         3'b000:  ext_c = {{24{byte_c[7]}}, byte_c};
         3'b001:  ext_c = {{16{half_c[15]}}, half_c};
         3'b100:  ext_c = {24'h000000, byte_c};
         3'b101:  ext_c = {16'h0000, half_c};
         default: ext_c = bus_rdata;
      endcase
   end

   // Limit reached on this REQ cycle; a zero limit disables the timeout
   assign timeout_c = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // Sequencer FSM with registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         is_load_q   <= 1'b0;
         funct3_q    <= 3'b000;
         addr_q      <= 32'h0;
         wdata_q     <= 32'h0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= 32'h0;
         bus_wstrb_q <= 4'b0000;
         bus_wdata_q <= 32'h0;
         mem_rdata_q <= 32'h0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  is_load_q <= is_load;
                  funct3_q  <= funct3;
                  addr_q    <= addr;
                  wdata_q   <= wdata;
                  busy_q    <= 1'b1;
                  err_q     <= 1'b0;
                  state_q   <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (!legal_c) begin
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  cnt_q       <= '0;
                  bus_req_q   <= 1'b1;
                  bus_we_q    <= ~is_load_q;
                  bus_addr_q  <= {addr_q[31:2], 2'b00};
                  bus_wstrb_q <= is_load_q ? 4'b0000 : strb_c;
                  bus_wdata_q <= is_load_q ? 32'h0 : wdata_rep_c;
                  state_q     <= S_REQ;
               end
            end
            S_REQ: begin
               // Ack wins over a timeout landing on the same cycle
               if (bus_ack) begin
                  bus_req_q <= 1'b0;
                  done_q    <= 1'b1;
                  err_q     <= 1'b0;
                  if (is_load_q) begin
                     mem_rdata_q <= ext_c;
                  end
                  state_q   <= S_DONE;
               end else if (timeout_c) begin
                  bus_req_q <= 1'b0;
                  done_q    <= 1'b1;
                  err_q     <= 1'b1;
                  state_q   <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               err_q   <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign mem_rdata = mem_rdata_q;
   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wstrb = bus_wstrb_q;
   assign bus_wdata = bus_wdata_q;

endmodule
